mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 107 ++++++++++
 1 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// mem_responder: fixed-latency 16-bit word memory with registered, pulsed responses.
// Rev 1.0

module mem_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        stall,
  output logic        misalign
);

  localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          count;
  logic [ADDR_W-1:0]   lat_idx;
  logic                lat_wr;
  logic [15:0]         lat_data;
  logic                lat_odd;
  logic [15:0]         mem [0:(1<<ADDR_W)-1];
  logic                commit;
  logic                unused_addr_bits;

  assign commit           = (state == BUSY) && (count == 4'd1);
  assign unused_addr_bits = ^addr[15:ADDR_W+1];

  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      stall = ((state == IDLE) && (enable || wr)) || (state == BUSY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= 4'd0;
      data_out   <= 16'd0;
      data_valid <= 1'b0;
      misalign   <= 1'b0;
      lat_idx    <= '0;
      lat_wr     <= 1'b0;
      lat_data   <= 16'd0;
      lat_odd    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      misalign   <= 1'b0;
      case (state)
        IDLE: begin
          if (enable || wr) begin
            lat_idx  <= addr[ADDR_W:1];
            lat_wr   <= wr;
            lat_data <= data_in;
            lat_odd  <= addr[0];
            count    <= LOAD_COUNT;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (commit) begin
            state      <= DONE;
            count      <= 4'd0;
            data_valid <= 1'b1;
            misalign   <= lat_odd;
            // Writes leave data_out holding the last read response.
            if (!lat_wr) begin
              data_out <= mem[lat_idx];
            end
          end else begin
            count <= count - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Storage is never reset; a reset during BUSY suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && lat_wr) begin
      mem[lat_idx] <= lat_data;
    end
  end

endmodule

`default_nettype wire
